sram_bw_ctrl: RTL and testbench

Request/response controller that sits directly upstream of the 64×128 single-port bit-write-enable SRAM macro. It zero-fills the array after reset, then converts a valid/ready request stream with byte write masks into the macro's active-low CEB/WEB/BWEB controls. It also captures the one-cycle-latency read data and holds it until the consumer accepts it. The macro's Q is valid only in the cycle after a read, so this block is the only place read data is made stable.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_bw_ctrl_if.sv | 33 +++
 rtl/sram_resp_skid.sv | 33 +++
 rtl/sram_bw_ctrl.sv | 90 +++++++++
 tb/tb_sram_bw_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types, widths and helpers for the bit-write SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Byte enables widened to one enable per data bit (active-high).
  function automatic logic [DATA_W-1:0] expand_mask(input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MASK_W); i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_bw_ctrl_if.sv
// Request/response stream plus macro pin bundle for sram_bw_ctrl.
interface sram_bw_ctrl_if;
  import sram_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              sram_CEB;
  logic              sram_WEB;
  logic [DATA_W-1:0] sram_BWEB;
  logic [ADDR_W-1:0] sram_A;
  logic [DATA_W-1:0] sram_D;
  logic [DATA_W-1:0] sram_Q;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready, sram_Q,
    output req_ready, resp_valid, resp_rdata,
    output sram_CEB, sram_WEB, sram_BWEB, sram_A, sram_D
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready, sram_Q,
    input  req_ready, resp_valid, resp_rdata,
    input  sram_CEB, sram_WEB, sram_BWEB, sram_A, sram_D
  );

endinterface

// File: rtl/sram_resp_skid.sv
// Read response stage: passes macro Q through in the read-data cycle and
// parks it in a hold register if the consumer stalls.
module sram_resp_skid
  import sram_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_pending_i,
  input  logic [DATA_W-1:0] sram_q_i,
  input  logic              resp_ready_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o
);

  logic              hold_valid_q;
  logic [DATA_W-1:0] hold_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (rd_pending_i && !resp_ready_i) begin
      hold_valid_q <= 1'b1;
      hold_q       <= sram_q_i;
    end else if (resp_ready_i) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign resp_valid_o = rd_pending_i || hold_valid_q;
  assign resp_rdata_o = (rd_pending_i && !hold_valid_q) ? sram_q_i : hold_q;

endmodule

// File: rtl/sram_bw_ctrl.sv
// Zero-fills the 64x128 bit-write SRAM after reset, then maps a valid/ready
// request stream onto the macro's active-low controls and returns read data.
module sram_bw_ctrl
  import sram_ctrl_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  sram_bw_ctrl_if.slave bus,
  output logic          init_done
);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              rd_pending_q;
  logic              init_done_q;
  logic              req_ready_c;
  logic              req_fire_c;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  assign req_ready_c = !RST && (state_q == S_RUN) && (!resp_valid || bus.resp_ready);
  assign req_fire_c  = bus.req_valid && req_ready_c;

  // Init sequencer and read-pending tracking.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      rd_pending_q <= req_fire_c && !bus.req_wen;
      unique case (state_q)
        S_INIT: begin
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Macro controls are sampled on the same edge that accepts the request.
  always_comb begin
    bus.sram_CEB  = 1'b1;
    bus.sram_WEB  = 1'b1;
    bus.sram_BWEB = '1;
    bus.sram_A    = '0;
    bus.sram_D    = '0;
    if (!RST) begin
      if (state_q == S_INIT) begin
        bus.sram_CEB  = 1'b0;
        bus.sram_WEB  = 1'b0;
        bus.sram_BWEB = '0;
        bus.sram_A    = cnt_q;
      end else if (req_fire_c) begin
        bus.sram_CEB = 1'b0;
        bus.sram_A   = bus.req_addr;
        if (bus.req_wen) begin
          bus.sram_WEB  = 1'b0;
          bus.sram_D    = bus.req_wdata;
          bus.sram_BWEB = ~expand_mask(bus.req_wmask);
        end
      end
    end
  end

  sram_resp_skid u_skid (
    .clk_i        (CLK),
    .rst_i        (RST),
    .rd_pending_i (rd_pending_q),
    .sram_q_i     (bus.sram_Q),
    .resp_ready_i (bus.resp_ready),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata)
  );

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign init_done      = init_done_q;

endmodule

// File: tb/tb_sram_bw_ctrl.sv
// Scoreboard bench for sram_bw_ctrl with a behavioural bit-write SRAM macro.
module tb_sram_bw_ctrl;
  import sram_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic init_done;

  sram_bw_ctrl_if bus ();

  sram_bw_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .init_done (init_done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mem [DEPTH];

  logic rr_random   = 1'b0;
  logic rr_force    = 1'b1;
  logic rr_rand_bit = 1'b1;

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Macro model: Q is meaningful only in the cycle after a read, garbage otherwise.
  always @(posedge CLK) begin
    if (!bus.sram_CEB && !bus.sram_WEB) begin
      mem[bus.sram_A] <= (mem[bus.sram_A] & bus.sram_BWEB) | (bus.sram_D & ~bus.sram_BWEB);
      bus.sram_Q      <= rand_data();
    end else if (!bus.sram_CEB) begin
      bus.sram_Q <= mem[bus.sram_A];
    end else begin
      bus.sram_Q <= rand_data();
    end
  end

  always @(posedge CLK) rr_rand_bit <= ($urandom_range(0, 3) != 0);
  assign bus.resp_ready = rr_random ? rr_rand_bit : rr_force;

  task automatic chk(input bit ok, input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as an array of words updated byte by byte.
  task automatic push_ref(input logic wen, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input logic [MASK_W-1:0] mask);
    if (wen) begin
      for (int b = 0; b < int'(MASK_W); b++)
        if (mask[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
    end else begin
      exp_q.push_back(ref_mem[addr]);
    end
  endtask

  task automatic set_req(input logic wen, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [MASK_W-1:0] mask);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    bus.req_wmask = mask;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
  endtask

  task automatic align();
    @(posedge CLK);
    #1;
  endtask

  // Presents a request until accepted; returns just after the accepting edge.
  task automatic issue(input logic wen, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input logic [MASK_W-1:0] mask);
    bit ok;
    ok = 1'b0;
    set_req(wen, addr, data, mask);
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk(1'b0, "req_ready_timeout", DATA_W'(bus.req_ready), DATA_W'(1));
      idle();
    end else begin
      push_ref(wen, addr, data, mask);
      align();
    end
  endtask

  task automatic check_reset_values(input string name);
    chk(bus.sram_CEB && bus.sram_WEB && (bus.sram_BWEB == '1) && (bus.sram_A == '0) &&
        (bus.sram_D == '0) && !bus.req_ready && !bus.resp_valid && (bus.resp_rdata == '0) &&
        !init_done, name,
        DATA_W'({bus.sram_CEB, bus.sram_WEB, bus.req_ready, bus.resp_valid, init_done, bus.sram_A}),
        DATA_W'({5'b11000, 6'd0}));
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
  endtask

  // Follows the zero-fill sweep; stops early at the negedge where A == stop_at.
  task automatic check_init(input int stop_at);
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge CLK);
      chk((bus.sram_A == ADDR_W'(i)) && !bus.sram_CEB && !bus.sram_WEB && (bus.sram_BWEB == '0) &&
          (bus.sram_D == '0) && !bus.req_ready && !init_done, "init_write",
          DATA_W'({bus.sram_CEB, bus.sram_WEB, bus.req_ready, init_done, bus.sram_A}),
          DATA_W'({4'b0000, ADDR_W'(i)}));
      if (i == stop_at) return;
    end
    @(negedge CLK);
    chk(init_done && bus.req_ready, "init_done", DATA_W'({init_done, bus.req_ready}), DATA_W'(2'b11));
  endtask

  task automatic stimulus();
    logic [DATA_W-1:0] a5;
    a5 = {16{8'hA5}};
    idle();
    #2 RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_values("reset_values");
    release_reset();
    check_init(30);
    RST = 1'b1;
    #1;
    check_reset_values("reset_mid_init");
    release_reset();
    check_init(-1);
    align();

    issue(1'b1, 6'd5, a5, 16'hFFFF);
    issue(1'b0, 6'd5, '0, '0);
    idle();
    @(negedge CLK);
    chk(bus.resp_valid && (bus.resp_rdata == a5), "raw_addr5", bus.resp_rdata, a5);
    align();

    issue(1'b1, 6'd7, '1, 16'h0001);
    idle();
    @(negedge CLK);
    chk(!bus.resp_valid, "write_no_resp", DATA_W'(bus.resp_valid), DATA_W'(0));
    align();
    issue(1'b0, 6'd7, '0, '0);
    idle();
    @(negedge CLK);
    chk(bus.resp_rdata == DATA_W'(8'hFF), "mask_byte0", bus.resp_rdata, DATA_W'(8'hFF));
    align();

    issue(1'b1, 6'd5, rand_data(), 16'h0000);
    issue(1'b1, 6'd2, rand_data(), 16'hF0F0);
    idle();

    rr_force = 1'b0;
    issue(1'b0, 6'd5, '0, '0);
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk(bus.resp_valid && (bus.resp_rdata == a5), "hold_rdata", bus.resp_rdata, a5);
      chk(!bus.req_ready, "hold_req_ready", DATA_W'(bus.req_ready), DATA_W'(0));
      align();
    end
    rr_force = 1'b1;
    @(negedge CLK);
    chk(bus.req_ready, "hold_release_ready", DATA_W'(bus.req_ready), DATA_W'(1));
    align();

    for (int a = 1; a <= 3; a++) begin
      set_req(1'b0, ADDR_W'(a), '0, '0);
      @(negedge CLK);
      chk(bus.req_ready, "b2b_ready", DATA_W'(bus.req_ready), DATA_W'(1));
      if (a > 1) chk(bus.resp_valid, "b2b_valid", DATA_W'(bus.resp_valid), DATA_W'(1));
      push_ref(1'b0, ADDR_W'(a), '0, '0);
      align();
    end
    idle();
    @(negedge CLK);
    chk(bus.resp_valid, "b2b_valid_last", DATA_W'(bus.resp_valid), DATA_W'(1));
    align();

    rr_random = 1'b1;
    repeat (300) begin
      issue(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), rand_data(),
            MASK_W'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        align();
      end
    end
    idle();
    rr_random = 1'b0;
    rr_force  = 1'b1;
    repeat (6) @(posedge CLK);
    chk(exp_q.size() == 0, "drain", DATA_W'(exp_q.size()), DATA_W'(0));
  endtask

  // Scoreboard monitor: every visible response must match the queue head.
  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (!RST && bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_resp", bus.resp_rdata, '0);
        end else begin
          chk(bus.resp_rdata == exp_q[0], "resp_rdata", bus.resp_rdata, exp_q[0]);
          if (bus.resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    fork
      stimulus();
      monitor();
      begin
        #200000;
        chk(1'b0, "global_timeout", '0, '1);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
